// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arc4_pkg
//  Description : Shared ARC4 definitions: KSA state encoding and default
//                S-memory depth / per-iteration cycle constants. Used by the
//                key-scheduling engine and by the PRGA / crack blocks.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package arc4_pkg;

    // Default S-memory depth (ADDR_W = 8)
    localparam int S_DEPTH     = 256;
    // Memory cycles spent on one KSA swap iteration (RD_I..WR_J)
    localparam int ITER_CYCLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_RD_I   = 3'd2,
        ST_WAIT_I = 3'd3,
        ST_RD_J   = 3'd4,
        ST_WAIT_J = 3'd5,
        ST_WR_I   = 3'd6,
        ST_WR_J   = 3'd7
    } ksa_state_t;

endpackage : arc4_pkg
`default_nettype wire

// File: rtl/key_byte_sel.sv
`default_nettype none
// ============================================================================
//  Module      : key_byte_sel
//  Description : Selects one byte of a multi-byte key. Byte 0 is the most
//                significant byte of i_key. Out-of-range indices return 0.
//  Ports       : i_key  [8*KEY_BYTES-1:0]  key vector
//                i_idx  [IDX_W-1:0]        byte index
//                o_byte [7:0]              selected key byte
//  Revision    : 1.0 - initial release
// ============================================================================
module key_byte_sel
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int IDX_W     = 2
) (
    input  logic [8*KEY_BYTES-1:0] i_key,
    input  logic [IDX_W-1:0]       i_idx,
    output logic [7:0]             o_byte
);

    always_comb begin
        o_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (i_idx == IDX_W'(b)) begin
                o_byte = i_key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule : key_byte_sel
`default_nettype wire

// File: rtl/ksa_param.sv
`default_nettype none
// ============================================================================
//  Module      : ksa_param
//  Description : Parametrised ARC4 key-scheduling engine. Optionally fills
//                S[k]=k, then runs the KSA swap loop over an external
//                synchronous S memory (1-cycle read latency).
//  Ports       : clk      clock, rising edge
//                rst      synchronous active-high reset
//                en       start request, accepted when rdy=1
//                do_init  1 = run init pass first (sampled with en)
//                key      [8*KEY_BYTES-1:0] key, byte 0 = MSB
//                rdy      idle / ready for en
//                addr     [ADDR_W-1:0] S-memory address
//                rddata   [DATA_W-1:0] S-memory read data
//                wrdata   [DATA_W-1:0] S-memory write data
//                wren     S-memory write enable
//  Revision    : 1.0 - initial release
// ============================================================================
module ksa_param
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   do_init,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   rdy,
    output logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      rddata,
    output logic [DATA_W-1:0]      wrdata,
    output logic                   wren
);

    localparam int                c_IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [ADDR_W-1:0] c_LAST      = '1;
    localparam logic [c_IDX_W-1:0] c_KIDX_LAST = c_IDX_W'(KEY_BYTES - 1);

    ksa_state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_addr, w_addr_nxt;
    logic [DATA_W-1:0]        r_wrdata, w_wrdata_nxt;
    logic                     r_wren, w_wren_nxt;
    logic [ADDR_W-1:0]        r_i, w_i_nxt;
    logic [ADDR_W-1:0]        r_j, w_j_nxt;
    logic [DATA_W-1:0]        r_si, w_si_nxt;
    logic [c_IDX_W-1:0]       r_kidx, w_kidx_nxt;
    logic [8*KEY_BYTES-1:0]   r_key, w_key_nxt;

    logic [7:0]               w_kb;
    logic [ADDR_W-1:0]        w_kb_a;
    logic [ADDR_W-1:0]        w_i_inc;
    logic [ADDR_W-1:0]        w_j_sum;

    key_byte_sel #(
        .KEY_BYTES (KEY_BYTES),
        .IDX_W     (c_IDX_W)
    ) u_key_byte_sel (
        .i_key  (r_key),
        .i_idx  (r_kidx),
        .o_byte (w_kb)
    );

    // Key byte enters the index sum at ADDR_W bits
    generate
        if (ADDR_W >= 8) begin : g_kb_ext
            assign w_kb_a = ADDR_W'(w_kb);
        end else begin : g_kb_trunc
            assign w_kb_a = w_kb[ADDR_W-1:0];
        end
    endgenerate

    assign w_i_inc = r_i + 1'b1;
    // Valid in WAIT_I, when rddata carries S[i]
    assign w_j_sum = r_j + rddata[ADDR_W-1:0] + w_kb_a;

    // Memory outputs are registered: each transition loads the addr/wrdata/
    // wren that belong to the state being entered.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_wrdata_nxt = r_wrdata;
        w_wren_nxt   = 1'b0;
        w_i_nxt      = r_i;
        w_j_nxt      = r_j;
        w_si_nxt     = r_si;
        w_kidx_nxt   = r_kidx;
        w_key_nxt    = r_key;

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_key_nxt  = key;
                    w_i_nxt    = '0;
                    w_j_nxt    = '0;
                    w_kidx_nxt = '0;
                    w_addr_nxt = '0;
                    if (do_init) begin
                        w_state_nxt  = ST_INIT;
                        w_wrdata_nxt = '0;
                        w_wren_nxt   = 1'b1;
                    end else begin
                        w_state_nxt  = ST_RD_I;
                    end
                end
            end
            ST_INIT: begin
                // r_i doubles as the init counter and wraps to 0 for the KSA
                w_i_nxt = w_i_inc;
                if (r_i == c_LAST) begin
                    w_state_nxt = ST_RD_I;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt   = w_i_inc;
                    w_wrdata_nxt = DATA_W'(w_i_inc);
                    w_wren_nxt   = 1'b1;
                end
            end
            ST_RD_I: begin
                w_state_nxt = ST_WAIT_I;
            end
            ST_WAIT_I: begin
                w_si_nxt    = rddata;
                w_j_nxt     = w_j_sum;
                w_kidx_nxt  = (r_kidx == c_KIDX_LAST) ? '0 : r_kidx + 1'b1;
                w_addr_nxt  = w_j_sum;
                w_state_nxt = ST_RD_J;
            end
            ST_RD_J: begin
                w_state_nxt = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                // rddata is S[j]; it goes straight out as the WR_I data
                w_addr_nxt   = r_i;
                w_wrdata_nxt = rddata;
                w_wren_nxt   = 1'b1;
                w_state_nxt  = ST_WR_I;
            end
            ST_WR_I: begin
                w_addr_nxt   = r_j;
                w_wrdata_nxt = r_si;
                w_wren_nxt   = 1'b1;
                w_state_nxt  = ST_WR_J;
            end
            ST_WR_J: begin
                w_i_nxt = w_i_inc;
                if (r_i == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_addr_nxt  = w_i_inc;
                    w_state_nxt = ST_RD_I;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wrdata <= '0;
            r_wren   <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_si     <= '0;
            r_kidx   <= '0;
            r_key    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_wrdata <= w_wrdata_nxt;
            r_wren   <= w_wren_nxt;
            r_i      <= w_i_nxt;
            r_j      <= w_j_nxt;
            r_si     <= w_si_nxt;
            r_kidx   <= w_kidx_nxt;
            r_key    <= w_key_nxt;
        end
    end

    assign rdy    = (r_state == ST_IDLE);
    assign addr   = r_addr;
    assign wrdata = r_wrdata;
    assign wren   = r_wren;

endmodule : ksa_param
`default_nettype wire

// File: tb/tb_ksa_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ksa_param
//  Description : Self-checking bench for ksa_param. Two instances (default
//                8-bit/3-byte and 4-bit/2-byte) each drive a behavioural
//                synchronous RAM; final S contents are compared against a
//                plain-arithmetic ARC4 KSA reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ksa_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic        en_b = 1'b0, do_init_b = 1'b0;
    logic [23:0] key_b = '0;
    logic        rdy_b, wren_b;
    logic [7:0]  addr_b, wrdata_b;
    logic [7:0]  rddata_b = '0;

    // Small instance
    logic        en_s = 1'b0, do_init_s = 1'b0;
    logic [15:0] key_s = '0;
    logic        rdy_s, wren_s;
    logic [3:0]  addr_s;
    logic [7:0]  wrdata_s;
    logic [7:0]  rddata_s = '0;

    ksa_param u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .do_init(do_init_b), .key(key_b),
        .rdy(rdy_b), .addr(addr_b), .rddata(rddata_b), .wrdata(wrdata_b), .wren(wren_b)
    );

    ksa_param #(.ADDR_W(4), .DATA_W(8), .KEY_BYTES(2)) u_dut_s (
        .clk(clk), .rst(rst), .en(en_s), .do_init(do_init_s), .key(key_s),
        .rdy(rdy_s), .addr(addr_s), .rddata(rddata_s), .wrdata(wrdata_s), .wren(wren_s)
    );

    // Behavioural RAMs with preload port and a small write log
    logic [7:0] mem_b [256];
    logic [7:0] pre_b [256];
    logic       pre_ld_b = 1'b0;
    int         wr_cnt_b = 0;
    logic [7:0] w0a, w0d, w1a, w1d;

    logic [7:0] mem_s [16];
    logic [7:0] pre_s [16];
    logic       pre_ld_s = 1'b0;

    always @(posedge clk) begin
        if (pre_ld_b) begin
            for (int k = 0; k < 256; k++) mem_b[k] <= pre_b[k];
            wr_cnt_b <= 0;
        end else if (wren_b) begin
            mem_b[addr_b] <= wrdata_b;
            if (wr_cnt_b == 0) begin w0a <= addr_b; w0d <= wrdata_b; end
            if (wr_cnt_b == 1) begin w1a <= addr_b; w1d <= wrdata_b; end
            wr_cnt_b <= wr_cnt_b + 1;
        end
        rddata_b <= mem_b[addr_b];
    end

    always @(posedge clk) begin
        if (pre_ld_s) begin
            for (int k = 0; k < 16; k++) mem_s[k] <= pre_s[k];
        end else if (wren_s) begin
            mem_s[addr_s] <= wrdata_s;
        end
        rddata_s <= mem_s[addr_s];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int ref_s [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference ARC4 KSA on ref_s (optionally starting from identity)
    task automatic ref_run(input int n, input int l, input logic [31:0] k, input bit di);
        int j, t, kb;
        if (di) for (int x = 0; x < n; x++) ref_s[x] = x;
        j = 0;
        for (int x = 0; x < n; x++) begin
            kb = int'((k >> (8 * (l - 1 - (x % l)))) & 32'hFF);
            j  = (j + ref_s[x] + kb) % n;
            t = ref_s[x]; ref_s[x] = ref_s[j]; ref_s[j] = t;
        end
    endtask

    task automatic preload_b(input bit ident);
        for (int k = 0; k < 256; k++) begin
            pre_b[k] = ident ? 8'(k) : 8'($urandom);
            ref_s[k] = int'(pre_b[k]);
        end
        @(negedge clk); pre_ld_b = 1'b1;
        @(negedge clk); pre_ld_b = 1'b0;
    endtask

    task automatic preload_s(input bit ident);
        for (int k = 0; k < 16; k++) begin
            pre_s[k] = ident ? 8'(k) : 8'($urandom);
            ref_s[k] = int'(pre_s[k]);
        end
        @(negedge clk); pre_ld_s = 1'b1;
        @(negedge clk); pre_ld_s = 1'b0;
    endtask

    task automatic cmp_b(input string tag);
        int errs = 0;
        for (int k = 0; k < 256; k++) if (mem_b[k] !== 8'(ref_s[k])) errs++;
        chk(tag, errs, 0);
    endtask

    task automatic cmp_s(input string tag);
        int errs = 0;
        for (int k = 0; k < 16; k++) if (mem_s[k] !== 8'(ref_s[k])) errs++;
        chk(tag, errs, 0);
    endtask

    task automatic run_b(input logic [23:0] k, input bit di, output int busy);
        @(negedge clk);
        chk("rdy_before_b", rdy_b, 1);
        en_b = 1'b1; key_b = k; do_init_b = di;
        @(negedge clk);
        en_b = 1'b0;
        busy = 0;
        while (rdy_b !== 1'b1 && busy < 4000) begin busy++; @(negedge clk); end
    endtask

    task automatic run_s(input logic [15:0] k, input bit di, output int busy);
        @(negedge clk);
        chk("rdy_before_s", rdy_s, 1);
        en_s = 1'b1; key_s = k; do_init_s = di;
        @(negedge clk);
        en_s = 1'b0;
        busy = 0;
        while (rdy_s !== 1'b1 && busy < 1000) begin busy++; @(negedge clk); end
    endtask

    initial begin
        int          busy;
        logic [23:0] k1, k2;
        logic [15:0] ks;
        bit          di;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdy_b", rdy_b, 1);
        chk("rst_wren_b", wren_b, 0);
        chk("rst_addr_b", addr_b, 0);
        chk("rst_wrdata_b", wrdata_b, 0);
        chk("rst_rdy_s", rdy_s, 1);
        chk("rst_wren_s", wren_s, 0);
        chk("rst_addr_s", addr_s, 0);
        chk("rst_wrdata_s", wrdata_s, 0);
        rst = 1'b0;

        // Default key with init pass over random memory
        preload_b(1'b0);
        run_b(24'h00033C, 1'b1, busy);
        chk("init_busy", busy, 1792);
        ref_run(256, 3, 32'h00033C, 1'b1);
        cmp_b("init_s");

        // Same key, KSA only over pre-initialised S
        preload_b(1'b1);
        run_b(24'h00033C, 1'b0, busy);
        chk("noinit_busy", busy, 1536);
        ref_run(256, 3, 32'h00033C, 1'b0);
        cmp_b("noinit_s");

        // Small configuration
        preload_s(1'b0);
        run_s(16'hA55A, 1'b1, busy);
        chk("small_busy", busy, 112);
        ref_run(16, 2, 32'hA55A, 1'b1);
        cmp_s("small_s");

        // i == j at i = 0: first two writes both hit S[0] with value 0
        k1 = {8'h00, 16'($urandom)};
        preload_b(1'b1);
        run_b(k1, 1'b0, busy);
        chk("ieqj_busy", busy, 1536);
        chk("ieqj_w0_addr", w0a, 0);
        chk("ieqj_w0_data", w0d, 0);
        chk("ieqj_w1_addr", w1a, 0);
        chk("ieqj_w1_data", w1d, 0);
        chk("ieqj_wr_count", wr_cnt_b, 512);
        ref_run(256, 3, 32'(k1), 1'b0);
        cmp_b("ieqj_s");

        // Reset pulse mid-run
        @(negedge clk);
        en_b = 1'b1; do_init_b = 1'b1; key_b = 24'($urandom);
        @(negedge clk);
        en_b = 1'b0;
        repeat (499) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rdy", rdy_b, 1);
        chk("midrst_wren", wren_b, 0);
        chk("midrst_addr", addr_b, 0);
        rst = 1'b0;
        k1 = 24'($urandom);
        run_b(k1, 1'b1, busy);
        chk("midrst_busy", busy, 1792);
        ref_run(256, 3, 32'(k1), 1'b1);
        cmp_b("midrst_s");

        // en held high across two back-to-back runs
        preload_b(1'b0);
        k1 = 24'($urandom);
        k2 = 24'($urandom);
        @(negedge clk);
        en_b = 1'b1; do_init_b = 1'b1; key_b = k1;
        @(negedge clk);
        key_b = k2;
        busy = 0;
        while (rdy_b !== 1'b1 && busy < 4000) begin busy++; @(negedge clk); end
        chk("hold_busy1", busy, 1792);
        ref_run(256, 3, 32'(k1), 1'b1);
        cmp_b("hold_s1");
        @(negedge clk);
        chk("hold_restart", rdy_b, 0);
        busy = 1;
        @(negedge clk);
        while (rdy_b !== 1'b1 && busy < 4000) begin busy++; @(negedge clk); end
        en_b = 1'b0;
        chk("hold_busy2", busy, 1792);
        ref_run(256, 3, 32'(k2), 1'b1);
        cmp_b("hold_s2");

        // Randomised runs on both configurations
        for (int r = 0; r < 3; r++) begin
            k1 = 24'($urandom);
            di = 1'($urandom);
            preload_b(1'b0);
            run_b(k1, di, busy);
            chk("rand_busy_b", busy, di ? 1792 : 1536);
            ref_run(256, 3, 32'(k1), di);
            cmp_b("rand_s_b");
        end
        for (int r = 0; r < 4; r++) begin
            ks = 16'($urandom);
            di = 1'($urandom);
            preload_s(1'b0);
            run_s(ks, di, busy);
            chk("rand_busy_s", busy, di ? 112 : 96);
            ref_run(16, 2, 32'(ks), di);
            cmp_s("rand_s_s");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ksa_param
`default_nettype wire
